user_credits_rd_mc: RTL

USER_CREDITS_RD_MC -- requirements
Module: user_credits_rd_mc

---
 rtl/user_credits_rd_mc.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/user_credits_rd_mc.sv
// user_credits_rd_mc
//   Credit-limited merge of N_CHAN read-request channels onto one request
//   port. Each accepted request is converted to a beat count and queued per
//   channel; a per-channel IDLE/READ FSM retires requests as read beats
//   (rxfer) arrive, returning one credit per completed request.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_req_valid/ready   per-channel request handshake
//   s_req_len           per-channel byte length, channel i at [i*LEN_BITS +: LEN_BITS]
//   m_req_valid/ready   merged request handshake (registered output)
//   m_req_len/chan      forwarded byte length and source channel
//   rxfer               per-channel read beat consumed this cycle
//   cred_cnt            per-channel outstanding-request count
//   err_zero_len        sticky: zero-length request seen
//   err_rxfer           sticky: rxfer seen while channel idle
module user_credits_rd_mc #(
  parameter int unsigned N_CHAN        = 4,
  parameter int unsigned DATA_BITS     = 512,
  parameter int unsigned LEN_BITS      = 28,
  parameter int unsigned N_OUTSTANDING = 8,
  localparam int unsigned CRED_BITS    = $clog2(N_OUTSTANDING + 1),
  localparam int unsigned CH_BITS      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_CHAN-1:0]           s_req_valid,
  output logic [N_CHAN-1:0]           s_req_ready,
  input  logic [N_CHAN*LEN_BITS-1:0]  s_req_len,
  output logic                        m_req_valid,
  input  logic                        m_req_ready,
  output logic [LEN_BITS-1:0]         m_req_len,
  output logic [CH_BITS-1:0]          m_req_chan,
  input  logic [N_CHAN-1:0]           rxfer,
  output logic [N_CHAN*CRED_BITS-1:0] cred_cnt,
  output logic [N_CHAN-1:0]           err_zero_len,
  output logic [N_CHAN-1:0]           err_rxfer
);

  localparam int unsigned BEAT_SHIFT = $clog2(DATA_BITS / 8);
  localparam int unsigned CNT_BITS   = LEN_BITS - BEAT_SHIFT;
  localparam int unsigned PTR_BITS   = $clog2(N_OUTSTANDING);
  localparam logic [CRED_BITS-1:0] CRED_MAX = CRED_BITS'(N_OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  logic [N_CHAN-1:0]   elig;
  logic [N_CHAN-1:0]   done;
  logic [N_CHAN-1:0]   grant_vec;
  logic [N_CHAN-1:0]   zero_acc;
  logic [LEN_BITS-1:0] len_arr [N_CHAN];

  logic                grant_any;
  logic [CH_BITS-1:0]  grant_idx;
  logic [CH_BITS-1:0]  rr_q, rr_d;
  logic                out_free;

  logic                m_valid_q, m_valid_d;
  logic [LEN_BITS-1:0] m_len_q, m_len_d;
  logic [CH_BITS-1:0]  m_chan_q, m_chan_d;

  // ---------------------------------------------------------------------
  // Round-robin arbiter feeding the single output register
  // ---------------------------------------------------------------------
  assign out_free = !m_valid_q || m_req_ready;

  always_comb begin
    logic [CH_BITS-1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (out_free && !areset) begin
      for (int unsigned k = 0; k < N_CHAN; k++) begin
        idx = CH_BITS'((32'(rr_q) + k) % N_CHAN);
        if (!grant_any && elig[idx]) begin
          grant_any = 1'b1;
          grant_idx = idx;
        end
      end
    end
    grant_vec[grant_idx] = grant_any;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_any) begin
      rr_d = (grant_idx == CH_BITS'(N_CHAN - 1)) ? '0 : grant_idx + CH_BITS'(1);
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_len_d   = m_len_q;
    m_chan_d  = m_chan_q;
    if (grant_any) begin
      m_valid_d = 1'b1;
      m_len_d   = len_arr[grant_idx];
      m_chan_d  = grant_idx;
    end else if (m_req_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_q      <= '0;
      m_valid_q <= 1'b0;
      m_len_q   <= '0;
      m_chan_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      m_valid_q <= m_valid_d;
      m_len_q   <= m_len_d;
      m_chan_q  <= m_chan_d;
    end
  end

  assign m_req_valid = m_valid_q;
  assign m_req_len   = m_len_q;
  assign m_req_chan  = m_chan_q;

  // Zero-length requests are consumed outside arbitration: they never
  // compete for the output register nor move the round-robin pointer.
  assign s_req_ready = areset ? '0 : (grant_vec | zero_acc);

  // ---------------------------------------------------------------------
  // Per-channel beat FIFO, read FSM and credit counter
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
    logic [LEN_BITS-1:0]  len;
    logic [CNT_BITS-1:0]  beats_m1;
    logic [CNT_BITS-1:0]  fifo_q [N_OUTSTANDING];
    logic [PTR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CRED_BITS-1:0] fifo_cnt_q;
    logic [CRED_BITS-1:0] cred_q, cred_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop, done_c;
    logic                 err_z_q, err_r_q;

    assign len          = s_req_len[g*LEN_BITS +: LEN_BITS];
    assign len_arr[g]   = len;
    assign beats_m1     = CNT_BITS'((len - LEN_BITS'(1)) >> BEAT_SHIFT);
    assign fifo_full    = (fifo_cnt_q == CRED_MAX);
    assign fifo_empty   = (fifo_cnt_q == '0);
    assign zero_acc[g]  = s_req_valid[g] && (len == '0);
    // Fullness is judged on the current count: a same-cycle done pop does
    // not open a slot for a grant into an already full FIFO.
    assign elig[g]      = s_req_valid[g] && (len != '0) &&
                          ((cred_q < CRED_MAX) || done_c) && !fifo_full;
    assign push         = grant_vec[g];
    assign done[g]      = done_c;

    always_ff @(posedge aclk) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (!fifo_empty) state_d = READ;
        READ:    if (done_c && fifo_empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      done_c = 1'b0;
      pop    = 1'b0;
      cnt_d  = cnt_q;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop   = 1'b1;
            cnt_d = fifo_q[rd_ptr_q];
          end
        end
        READ: begin
          if (rxfer[g]) begin
            if (cnt_q == '0) begin
              done_c = 1'b1;
              if (!fifo_empty) begin
                pop   = 1'b1;
                cnt_d = fifo_q[rd_ptr_q];
              end
            end else begin
              cnt_d = cnt_q - CNT_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end

    always_comb begin
      cred_d = cred_q;
      if (push && !done_c)      cred_d = cred_q + CRED_BITS'(1);
      else if (done_c && !push) cred_d = cred_q - CRED_BITS'(1);
    end

    always_ff @(posedge aclk) begin
      if (push) fifo_q[wr_ptr_q] <= beats_m1;
    end

    always_ff @(posedge aclk) begin
      if (areset) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
        cnt_q      <= '0;
        cred_q     <= '0;
        err_z_q    <= 1'b0;
        err_r_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
        if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CRED_BITS'(1);
        else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - CRED_BITS'(1);
        cnt_q  <= cnt_d;
        cred_q <= cred_d;
        if (zero_acc[g])                   err_z_q <= 1'b1;
        if (rxfer[g] && (state_q == IDLE)) err_r_q <= 1'b1;
      end
    end

    assign cred_cnt[g*CRED_BITS +: CRED_BITS] = cred_q;
    assign err_zero_len[g] = err_z_q;
    assign err_rxfer[g]    = err_r_q;
  end

endmodule
